// File: rtl/mioc_pattern_engine.sv
// Purpose   : on-chip stimulus table player; drives a register under test, samples it, streams records.
// Latency   : first record valid SETTLE+1 cycles after the APPLY cycle; SETTLE+2 cycles per vector.
// Backpress : cap_ready low parks the engine in EMIT; dut_in and all record fields hold, no sampling.
//
// Ports:
//   i_clk, i_rst          single rising-edge clock, synchronous active-high reset
//   i_cfg_we/addr/wdata   table write port {mask, expect, stim}, honoured only while idle
//   i_cfg_len             vectors per run (0..DEPTH, larger values clamp), sampled on i_start
//   i_start               single-cycle run request, ignored while busy
//   o_busy, o_done        run in progress / one-cycle end-of-run pulse
//   o_dut_in, i_dut_out   registered drive to the DUT / DUT response (synchronous to i_clk)
//   o_cap_*               capture record stream (valid/ready) with index and masked-compare flag
//   o_err_cnt             saturating mismatch count for the current or last run
module mioc_pattern_engine #(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 2,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int SETTLE = 8,
    parameter int ERR_W  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cfg_we,
    input  logic [AW-1:0]           i_cfg_addr,
    input  logic [IN_W+2*OUT_W-1:0] i_cfg_wdata,
    input  logic [AW:0]             i_cfg_len,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [IN_W-1:0]         o_dut_in,
    input  logic [OUT_W-1:0]        i_dut_out,
    output logic                    o_cap_valid,
    input  logic                    i_cap_ready,
    output logic [IN_W+OUT_W-1:0]   o_cap_data,
    output logic [AW-1:0]           o_cap_index,
    output logic                    o_cap_mismatch,
    output logic [ERR_W-1:0]        o_err_cnt
);

    localparam int ENT_W = IN_W + 2 * OUT_W;
    localparam int CW    = $clog2(SETTLE + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_APPLY  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_EMIT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Pattern table; deliberately not reset so a host can preload it once.
    logic [ENT_W-1:0]       r_table [DEPTH];

    logic [2:0]             r_state;
    logic [AW-1:0]          r_idx;
    logic [AW-1:0]          r_last;
    logic [CW-1:0]          r_cnt;
    logic [IN_W-1:0]        r_dut_in;
    logic [IN_W+OUT_W-1:0]  r_cap_data;
    logic [AW-1:0]          r_cap_index;
    logic                   r_cap_mismatch;
    logic [ERR_W-1:0]       r_err_cnt;

    logic [ENT_W-1:0]       w_entry;
    logic [IN_W-1:0]        w_stim;
    logic [OUT_W-1:0]       w_expect;
    logic [OUT_W-1:0]       w_mask;
    logic                   w_mismatch;
    logic [AW-1:0]          w_last;
    logic                   w_handshake;

    // The table cannot change while a run is active, so the entry for the
    // current index can be re-read in SETTLE instead of being latched in APPLY.
    assign w_entry  = r_table[r_idx];
    assign w_stim   = w_entry[IN_W-1:0];
    assign w_expect = w_entry[IN_W+OUT_W-1:IN_W];
    assign w_mask   = w_entry[ENT_W-1:IN_W+OUT_W];

    assign w_mismatch  = |((i_dut_out ^ w_expect) & w_mask);
    assign w_handshake = (r_state == ST_EMIT) && i_cap_ready;

    // Index of the final vector; lengths above DEPTH run the whole table.
    assign w_last = (i_cfg_len > (AW+1)'(DEPTH)) ? AW'(DEPTH - 1)
                                                 : AW'(i_cfg_len - (AW+1)'(1));

    always_ff @(posedge i_clk) begin
        if (i_cfg_we && (r_state == ST_IDLE)) begin
            r_table[i_cfg_addr] <= i_cfg_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_last         <= '0;
            r_cnt          <= '0;
            r_dut_in       <= '0;
            r_cap_data     <= '0;
            r_cap_index    <= '0;
            r_cap_mismatch <= 1'b0;
            r_err_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_err_cnt <= '0;
                        r_idx     <= '0;
                        r_last    <= w_last;
                        r_state   <= (i_cfg_len == '0) ? ST_DONE : ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_dut_in <= w_stim;
                    r_cnt    <= CW'(SETTLE);
                    r_state  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // r_cnt==1 marks the SETTLE-th cycle with the new drive visible.
                    if (r_cnt == CW'(1)) begin
                        r_cap_data     <= {r_dut_in, i_dut_out};
                        r_cap_index    <= r_idx;
                        r_cap_mismatch <= w_mismatch;
                        if (w_mismatch && (r_err_cnt != {ERR_W{1'b1}})) begin
                            r_err_cnt <= r_err_cnt + ERR_W'(1);
                        end
                        r_state <= ST_EMIT;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_EMIT: begin
                    if (w_handshake) begin
                        if (r_idx == r_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + AW'(1);
                            r_state <= ST_APPLY;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and record valid decode straight from the state register.
    assign o_busy         = (r_state != ST_IDLE);
    assign o_done         = (r_state == ST_DONE);
    assign o_cap_valid    = (r_state == ST_EMIT);
    assign o_dut_in       = r_dut_in;
    assign o_cap_data     = r_cap_data;
    assign o_cap_index    = r_cap_index;
    assign o_cap_mismatch = r_cap_mismatch;
    assign o_err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_mioc_pattern_engine.sv
// Purpose   : self-checking bench for mioc_pattern_engine against a table-level reference model.
// Latency   : record timing checked against the SETTLE+2 per-vector cadence.
// Backpress : cap_ready driven high, randomly, and held low for long stalls.
module tb_mioc_pattern_engine;

    localparam int IN_W   = 4;
    localparam int OUT_W  = 2;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int SETTLE = 8;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [4:0] cfg_len;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] dut_in;
    logic [1:0] dut_out;
    logic       cap_valid;
    logic       cap_ready;
    logic [5:0] cap_data;
    logic [3:0] cap_index;
    logic       cap_mismatch;
    logic [15:0] err_cnt;

    // Second instance: small counter, deep table, SETTLE=1, to reach saturation quickly.
    logic       s_cfg_we;
    logic [4:0] s_cfg_addr;
    logic [7:0] s_cfg_wdata;
    logic [5:0] s_cfg_len;
    logic       s_start;
    logic       s_busy;
    logic       s_done;
    logic [3:0] s_dut_in;
    logic [1:0] s_dut_out;
    logic       s_cap_valid;
    logic       s_cap_ready;
    logic [5:0] s_cap_data;
    logic [4:0] s_cap_index;
    logic       s_cap_mismatch;
    logic [3:0] s_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the table contents as written by the host.
    logic [3:0] m_stim [DEPTH];
    logic [1:0] m_exp  [DEPTH];
    logic [1:0] m_mask [DEPTH];

    // Golden register under test: q = s3&s2 | s1^s0, outputs {q, qbar}.
    function automatic logic [1:0] gold(input logic [3:0] s);
        logic q;
        q = (s[3] & s[2]) | (s[1] ^ s[0]);
        return {q, ~q};
    endfunction

    function automatic bit mis(input int i);
        return |((gold(m_stim[i]) ^ m_exp[i]) & m_mask[i]);
    endfunction

    assign dut_out   = gold(dut_in);
    assign s_dut_out = gold(s_dut_in);

    mioc_pattern_engine #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AW(AW),
                          .SETTLE(SETTLE), .ERR_W(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
        .i_cfg_wdata(cfg_wdata), .i_cfg_len(cfg_len), .i_start(start),
        .o_busy(busy), .o_done(done), .o_dut_in(dut_in), .i_dut_out(dut_out),
        .o_cap_valid(cap_valid), .i_cap_ready(cap_ready), .o_cap_data(cap_data),
        .o_cap_index(cap_index), .o_cap_mismatch(cap_mismatch), .o_err_cnt(err_cnt)
    );

    mioc_pattern_engine #(.IN_W(4), .OUT_W(2), .DEPTH(32), .AW(5),
                          .SETTLE(1), .ERR_W(4)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_cfg_we(s_cfg_we), .i_cfg_addr(s_cfg_addr),
        .i_cfg_wdata(s_cfg_wdata), .i_cfg_len(s_cfg_len), .i_start(s_start),
        .o_busy(s_busy), .o_done(s_done), .o_dut_in(s_dut_in), .i_dut_out(s_dut_out),
        .o_cap_valid(s_cap_valid), .i_cap_ready(s_cap_ready), .o_cap_data(s_cap_data),
        .o_cap_index(s_cap_index), .o_cap_mismatch(s_cap_mismatch), .o_err_cnt(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks enter and leave at #1 after a rising edge.
    task automatic write_entry(input int a, input logic [3:0] s, input logic [1:0] e,
                               input logic [1:0] m);
        cfg_we    = 1'b1;
        cfg_addr  = a[3:0];
        cfg_wdata = {m, e, s};
        @(posedge clk); #1;
        cfg_we    = 1'b0;
        m_stim[a] = s;
        m_exp[a]  = e;
        m_mask[a] = m;
    endtask

    task automatic run_vectors(input string nm, input int len, input int stall_idx,
                               input bit rand_rdy, input bit inject, input bit chk_spc);
        int nexp, exp_err, nrec, done_cnt, last_v, stall_left;
        bit in_rec, stall_bad, spc_bad, timed_out;
        logic [5:0]  snap_data;
        logic [3:0]  snap_idx, snap_din;
        logic        snap_mis;
        logic [15:0] snap_err;
        nexp = (len > DEPTH) ? DEPTH : len;
        exp_err = 0;
        for (int i = 0; i < nexp; i++) if (mis(i)) exp_err++;
        if (exp_err > 65535) exp_err = 65535;
        nrec = 0; done_cnt = 0; last_v = 0; stall_left = 0;
        in_rec = 0; stall_bad = 0; spc_bad = 0; timed_out = 1;
        snap_data = '0; snap_idx = '0; snap_din = '0; snap_mis = 1'b0; snap_err = '0;
        cfg_len = len[4:0];
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        for (int k = 1; k < 3000; k++) begin
            if (inject && k == 5) begin
                start     = 1'b1;
                cfg_we    = 1'b1;
                cfg_addr  = 4'd3;
                cfg_wdata = ~{m_mask[3], m_exp[3], m_stim[3]};
            end else if (inject && k == 6) begin
                start  = 1'b0;
                cfg_we = 1'b0;
            end
            if (done) done_cnt++;
            if (cap_valid) begin
                if (!in_rec) begin
                    in_rec = 1; snap_data = cap_data; snap_idx = cap_index;
                    snap_mis = cap_mismatch; snap_din = dut_in; snap_err = err_cnt;
                    if (chk_spc && ((nrec == 0) ? (k != SETTLE + 2) : (k - last_v != SETTLE + 2)))
                        spc_bad = 1;
                    last_v = k;
                    if (int'(cap_index) == stall_idx) stall_left = 20;
                end else if (cap_data !== snap_data || cap_index !== snap_idx ||
                             cap_mismatch !== snap_mis || dut_in !== snap_din ||
                             err_cnt !== snap_err) begin
                    stall_bad = 1;
                end
                if (stall_left > 0) begin
                    cap_ready = 1'b0;
                    stall_left--;
                end else begin
                    cap_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (cap_ready) begin
                    check({nm, "_index"}, cap_index, nrec[3:0]);
                    if (nrec < DEPTH) begin
                        check({nm, "_data"}, cap_data, {m_stim[nrec], gold(m_stim[nrec])});
                        check({nm, "_mismatch"}, cap_mismatch, mis(nrec));
                    end
                    nrec++;
                    in_rec = 0;
                end
            end else begin
                if (in_rec) stall_bad = 1;
                cap_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (done_cnt > 0 && !busy) begin
                timed_out = 0;
                break;
            end
            @(posedge clk); #1;
        end
        check({nm, "_timeout"}, timed_out, 0);
        check({nm, "_records"}, nrec, nexp);
        check({nm, "_done_pulses"}, done_cnt, 1);
        check({nm, "_err_cnt"}, err_cnt, exp_err);
        check({nm, "_stall_stable"}, stall_bad, 0);
        if (chk_spc) check({nm, "_spacing"}, spc_bad, 0);
        if (nexp > 0) check({nm, "_dut_in_hold"}, dut_in, m_stim[nexp-1]);
        cap_ready = 1'b1;
    endtask

    initial begin
        int nb, nd, nv, sd, srec, smis, snm, sexp;
        bit to, wrap;
        logic [3:0] st;
        logic [1:0] r;
        logic [3:0] sprev;
        rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cfg_len = 0; start = 0;
        cap_ready = 1'b1;
        s_cfg_we = 0; s_cfg_addr = 0; s_cfg_wdata = 0; s_cfg_len = 0; s_start = 0;
        s_cap_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dut_in", dut_in, 0);
        check("rst_cap_valid", cap_valid, 0);
        check("rst_cap_data", cap_data, 0);
        check("rst_cap_index", cap_index, 0);
        check("rst_cap_mismatch", cap_mismatch, 0);
        check("rst_err_cnt", err_cnt, 0);

        // Basic four-vector run against golden expectations.
        write_entry(0, 4'b0000, gold(4'b0000), 2'b11);
        write_entry(1, 4'b0001, gold(4'b0001), 2'b11);
        write_entry(2, 4'b1010, gold(4'b1010), 2'b11);
        write_entry(3, 4'b1111, gold(4'b1111), 2'b11);
        run_vectors("basic", 4, -1, 0, 0, 1);

        // Entry 2 expect inverted, then masked off.
        write_entry(2, 4'b1010, ~gold(4'b1010), 2'b11);
        run_vectors("mis2", 4, -1, 0, 0, 1);

        // Zero-length run clears err_cnt and emits nothing.
        cfg_len = 5'd0;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        check("len0_done_first", done, 1);
        nb = 0; nd = 0; nv = 0;
        for (int k = 0; k < 6; k++) begin
            nb += int'(busy); nd += int'(done); nv += int'(cap_valid);
            @(posedge clk); #1;
        end
        check("len0_busy_cycles", nb, 1);
        check("len0_done_cycles", nd, 1);
        check("len0_no_valid", nv, 0);
        check("len0_err_cnt", err_cnt, 0);

        write_entry(2, 4'b1010, ~gold(4'b1010), 2'b00);
        run_vectors("mask00", 4, -1, 0, 0, 1);

        // 20-cycle backpressure on record 1.
        write_entry(2, 4'b1010, gold(4'b1010), 2'b11);
        run_vectors("stall", 4, 1, 0, 0, 0);

        // Full random table, oversize length clamps to DEPTH, random ready.
        for (int i = 0; i < DEPTH; i++) begin
            st = 4'($urandom);
            write_entry(i, st, 2'($urandom), 2'($urandom));
        end
        run_vectors("len17", 17, -1, 1, 0, 0);

        // Stray start and table write during a run.
        run_vectors("inject", 4, -1, 0, 1, 1);
        run_vectors("after_inject", 16, -1, 1, 0, 0);

        // Reset during SETTLE of vector 2.
        write_entry(0, 4'b0011, gold(4'b0011), 2'b11);
        write_entry(1, 4'b0110, ~gold(4'b0110), 2'b11);
        write_entry(2, 4'b1100, gold(4'b1100), 2'b11);
        write_entry(3, 4'b1001, gold(4'b1001), 2'b11);
        cap_ready = 1'b1;
        cfg_len = 5'd4;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        nd = 0;
        for (int k = 1; k < 24; k++) begin
            nd += int'(done);
            @(posedge clk); #1;
        end
        check("rst_mid_pre_err", err_cnt, int'(mis(0)) + int'(mis(1)));
        check("rst_mid_pre_dut_in", dut_in, m_stim[2]);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_dut_in", dut_in, 0);
        check("rst_mid_cap_valid", cap_valid, 0);
        check("rst_mid_cap_data", cap_data, 0);
        check("rst_mid_cap_index", cap_index, 0);
        check("rst_mid_err_cnt", err_cnt, 0);
        for (int k = 0; k < 15; k++) begin
            nd += int'(done) + int'(busy);
            @(posedge clk); #1;
        end
        check("rst_mid_no_done", nd, 0);
        run_vectors("post_rst", 4, -1, 0, 0, 1);

        // Saturation of the error counter on the small-counter instance.
        snm = 0;
        for (int i = 0; i < 32; i++) begin
            st = 4'($urandom);
            r  = ~gold(st);
            if (|((gold(st) ^ r) & 2'b11)) snm++;
            s_cfg_we = 1'b1; s_cfg_addr = 5'(i); s_cfg_wdata = {2'b11, r, st};
            @(posedge clk); #1;
        end
        s_cfg_we = 1'b0;
        sexp = (snm > 15) ? 15 : snm;
        s_cfg_len = 6'd32;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        srec = 0; smis = 0; sd = 0; to = 1; wrap = 0; sprev = '0;
        for (int k = 0; k < 1000; k++) begin
            if (s_cap_valid) begin
                srec++;
                smis += int'(s_cap_mismatch);
            end
            if (s_err < sprev) wrap = 1;
            sprev = s_err;
            if (s_done) sd = 1;
            if (sd != 0 && !s_busy) begin
                to = 0;
                break;
            end
            @(posedge clk); #1;
        end
        check("sat_timeout", to, 0);
        check("sat_records", srec, 32);
        check("sat_mismatches", smis, snm);
        check("sat_err_cnt", s_err, sexp);
        check("sat_no_wrap", wrap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
